// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_add_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest operand width the sequencer supports
  localparam int WIDTH_MAX = 64;

endpackage : serial_add_pkg

// File: rtl/full_add_1bit.sv
// Single-bit full adder: the only arithmetic cell of the serial adder.
module full_add_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of one bit position
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_add_1bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts A, B and carry-in over valid/ready,
// adds one bit pair per cycle (LSB first) through a single full adder, and
// returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
// Optional macro SERIAL_ADD_SUB_EN adds a sub_in port selecting A-B.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  // Bit counter width is derived from WIDTH and is not a user parameter
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range 1..64");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   b_load;
  logic [CNT_W-1:0]   count;
  logic               carry;
  logic               carry_load;
  logic               fa_sum;
  logic               fa_cout;

  full_add_1bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operand B and initial carry as loaded at accept (inverted B and carry 1 for subtract)
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    b_load     = b_in;
    carry_load = cin_in;
`ifdef SERIAL_ADD_SUB_EN
    if (sub_in) begin
      b_load     = ~b_in;
      carry_load = 1'b1;
    end
`endif
  end

  // Sum register shifted right with the new sum bit entering at the MSB
  always_comb begin
    sum_next            = sum_sh >> 1;
    sum_next[WIDTH-1]   = fa_sum;
  end

  // Sequencer FSM with datapath registers and registered handshake outputs
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all registers are reset here; the shift registers are small flops, not a memory array.
      state     <= IDLE;
      count     <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a_in;
            b_sh     <= b_load;
            carry    <= carry_load;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_cout;
          count  <= count + 1'b1;
          if (count == LAST_BIT) begin
            // Final bit: publish the result; carry leaves only through cout_out
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            sum_out   <= sum_next;
            cout_out  <= fa_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_add_ctrl

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then feeds one bit pair per cycle (LSB first) through a single full_add_1bit instance. A registered carry connects successive bits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. This block trades area for latency wherever a wide ripple adder is not justified.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, must not be overridden.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands on a_in/b_in/cin_in are valid.
- in_ready, output, 1, block can accept operands.
- a_in, input, WIDTH, operand A.
- b_in, input, WIDTH, operand B.
- cin_in, input, 1, initial carry-in.
- out_valid, output, 1, result on sum_out/cout_out is valid.
- out_ready, input, 1, consumer accepts result.
- sum_out, output, WIDTH, A+B+cin, low WIDTH bits.
- cout_out, output, 1, carry out of bit WIDTH-1.
- busy, output, 1, high in RUN state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge: state<=IDLE, count<=0, carry<=0, shift registers<=0. Outputs after reset: in_ready=1, out_valid=0, sum_out=0, cout_out=0, busy=0.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> RUN on in_valid&&in_ready. At that edge: load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, count<=0.
- RUN, each cycle:
  - The adder sees a=a_sh[0], b=b_sh[0], cin=carry.
  - sum bit shifts into the MSB of sum_sh (right shift). a_sh and b_sh shift right. carry<=adder cout. count<=count+1.
  - When count==WIDTH-1, the final bit is processed that edge, then RUN -> DONE.
- DONE: sum_out=sum_sh and cout_out=carry, held stable while out_valid=1 && out_ready=0. DONE -> IDLE on out_ready.
- Latency: operands accepted at edge 0. out_valid is high after edge WIDTH. Minimum accept-to-accept period is WIDTH+2 cycles. No overlap; single operation in flight.
- Boundary conditions:
  - WIDTH=1: RUN lasts exactly one cycle.
  - Carry chain wraps into cout_out only, never into the LSB.
  - in_valid in RUN/DONE is ignored (in_ready=0). The source must hold its data.
  - out_ready high in IDLE/RUN has no effect.
  - rst asserted mid-RUN or in DONE aborts the operation next edge. The result is lost; out_valid=0.
- sum_out/cout_out outside DONE: hold the last result (0 after reset). Consumers qualify with out_valid.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined: adds input port sub_in (1 bit), sampled at accept.
  - When sub_in=1, b_sh loads ~b_in and carry loads 1 (cin_in ignored). The block computes A-B.
  - cout_out=1 means no borrow (A>=B unsigned).
  - sub_in=0 behaves as the base block.
- Undefined: no sub_in port; addition only.

Decomposition:
- Shared package serial_add_pkg:
  - state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - WIDTH_MAX=64 constant.
- Sub-module: exactly one instance of the existing full_add_1bit, named u_fa. No other sub-modules. Counter and shift registers stay inline.

Test Plan:
- Reset -> in_ready=1, out_valid=0, sum_out=0x00, cout_out=0, busy=0.
- WIDTH=8:
  - a=0x5A, b=0x33, cin=0 -> after 8 RUN cycles out_valid=1, sum=0x8D, cout=0.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles after DONE -> sum/cout stable, in_ready=0. out_ready=1 -> IDLE next cycle. A second operation (0x01+0x01) then returns 0x02.
- rst pulse at RUN cycle 3 -> IDLE next edge, out_valid never asserted. Next op 0x10+0x20 returns 0x30, cout 0 (no stale carry).
- With SERIAL_ADD_SUB_EN:
  - a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
